tx_frame_builder: RTL

Transmit-side frame assembler that sits directly upstream of the GMII transmit interface. It accepts a byte stream with a last-byte marker and writes the complete frame into the shared TX byte FIFO, padding to the minimum frame length and appending the IEEE 802.3 FCS. It then announces the frame's total byte count with a four-phase ready/ack handshake. The GMII interface consumes the FIFO and the count and adds preamble/SFD.

---
 rtl/tx_frame_builder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/tx_frame_builder.sv
// Transmit frame assembler: copies payload into the TX FIFO, zero-pads to MIN_LEN,
// appends the CRC-32 FCS and hands the total byte count over a four-phase handshake.
module tx_frame_builder #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  fifo_data,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic [10:0] word_count,
  output logic        word_count_ready,
  input  logic        word_count_ack,
  output logic        frame_truncated
);

  typedef enum logic [2:0] {
    S_IDLE, S_PAYLOAD, S_PAD, S_FCS, S_HANDOFF, S_RELEASE
  } state_t;

  localparam logic [10:0] MIN_CNT = 11'(MIN_LEN);
  localparam logic [10:0] MAX_CNT = 11'(MAX_LEN);

  state_t      state;
  logic [10:0] count;
  logic [10:0] next_count;
  logic [10:0] pay_count;
  logic [31:0] crc;
  logic [31:0] fcs;
  logic [1:0]  fcs_idx;
  logic        trunc_seen;
  logic        accept;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign s_ready = !rst && (state == S_IDLE || state == S_PAYLOAD) && !fifo_full;
  assign accept  = s_valid && s_ready;
  assign fcs     = ~crc;

  always_comb begin
    next_count = count + 11'd1;
    // Frame length as it will stand after the byte being accepted (dropped bytes do not count).
    pay_count  = (count == MAX_CNT) ? count : next_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      count            <= '0;
      crc              <= '1;
      fcs_idx          <= '0;
      trunc_seen       <= 1'b0;
      fifo_wr          <= 1'b0;
      fifo_data        <= '0;
      word_count       <= '0;
      word_count_ready <= 1'b0;
      frame_truncated  <= 1'b0;
    end else begin
      fifo_wr         <= 1'b0;
      frame_truncated <= 1'b0;
      case (state)
        // Counter, CRC and truncation flag are already clear on entry to S_IDLE,
        // so the first byte shares the payload path.
        S_IDLE, S_PAYLOAD: begin
          if (accept) begin
            state <= S_PAYLOAD;
            if (count == MAX_CNT) begin
              if (!trunc_seen) begin
                frame_truncated <= 1'b1;
                trunc_seen      <= 1'b1;
              end
            end else begin
              fifo_wr   <= 1'b1;
              fifo_data <= s_data;
              count     <= next_count;
              crc       <= crc_byte(crc, s_data);
            end
            if (s_last)
              state <= (pay_count < MIN_CNT) ? S_PAD : S_FCS;
          end
        end
        S_PAD: begin
          if (!fifo_full) begin
            fifo_wr   <= 1'b1;
            fifo_data <= 8'h00;
            count     <= next_count;
            crc       <= crc_byte(crc, 8'h00);
            if (next_count >= MIN_CNT)
              state <= S_FCS;
          end
        end
        S_FCS: begin
          if (!fifo_full) begin
            fifo_wr   <= 1'b1;
            fifo_data <= fcs[{fcs_idx, 3'b000} +: 8];
            count     <= next_count;
            fcs_idx   <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3)
              state <= S_HANDOFF;
          end
        end
        S_HANDOFF: begin
          if (!word_count_ready) begin
            word_count       <= count;
            word_count_ready <= 1'b1;
          end else if (word_count_ack) begin
            word_count_ready <= 1'b0;
            state            <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!word_count_ack) begin
            state      <= S_IDLE;
            count      <= '0;
            crc        <= '1;
            fcs_idx    <= '0;
            trunc_seen <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
